raster_out_handle: RTL and testbench
====================================

Name: raster_out_handle

Overview:
Parametrised successor to the pipeline's output handler. It consumes the Pixel/Frame/Line stream at the tail of the edge/Hough pipeline and converts it to raster coordinates (column i, row j) plus data. It also tracks frame completion and counts frames, so testbenches and downstream accumulators no longer count frames themselves. It detects malformed lines and frames and resynchronises after them.

Parameters:
PIX_W, 8, pixel data width
COORD_W, 8, width of i/j coordinate outputs; IMG_W-1 and IMG_H-1 must fit
IMG_W, 128, pixels per line
IMG_H, 128, lines per frame
FCNT_W, 16, frame counter width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
PixelIn  in  PIX_W  pixel data, qualified by ValidIn
ValidIn  in  1  pixel valid strobe
FrameIn  in  1  start-of-frame; high with first valid pixel of a frame
LineIn  in  1  start-of-line; high with first valid pixel of every line, including line 0
data  out  PIX_W  registered pixel
i  out  COORD_W  column of data
j  out  COORD_W  row of data
DataValid  out  1  data/i/j valid
FrameOut  out  1  one-cycle pulse, coincident with the last pixel (IMG_W-1, IMG_H-1)
FrameCount  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W
LineErr  out  1  one-cycle pulse on short or long line
FrameErr  out  1  one-cycle pulse on premature FrameIn
EdgeCount  out  2*COORD_W+1  non-zero pixels in last completed frame (see Optional Feature)

Behaviour:
- Reset, synchronous and active-high, clears every output and internal counter to 0 and puts the FSM in IDLE. Reset wins over all inputs in the same cycle, including mid-frame.
- All outputs are registered, with 1-cycle latency from the accepted input pixel.
- Inputs are sampled only when ValidIn=1. FrameIn and LineIn are ignored when ValidIn=0.
- FSM states:
  - IDLE: wait for FrameIn. Valid pixels without FrameIn are dropped, with no error.
  - ACTIVE: pixels are accepted and placed in the raster.
- IDLE -> ACTIVE: on a valid pixel with FrameIn=1. Output that pixel at (0,0), even if LineIn=0.
- In ACTIVE, the next position is computed from the current col/row:
  - Same line: if col < IMG_W-1 and LineIn=0, output at (col+1, row).
  - Normal new line: if col == IMG_W-1 and LineIn=1, output at (0, row+1).
  - Long line: if col == IMG_W-1 and LineIn=0, pulse LineErr and drop the pixel (DataValid=0). Position holds until LineIn arrives.
  - Short line: if col < IMG_W-1 and LineIn=1, pulse LineErr and output at (0, row+1).
  - Row past end: if either line rule would take row beyond IMG_H-1, pulse FrameErr, drop the pixel and return to IDLE.
- Frame completion:
  - Output at (IMG_W-1, IMG_H-1) asserts FrameOut in the same cycle as DataValid.
  - FrameCount increments in that same cycle.
  - FSM returns to IDLE.
- A valid FrameIn in ACTIVE before completion pulses FrameErr. The pixel restarts at (0,0), the FSM stays ACTIVE, and FrameCount is not incremented.
- A FrameIn on the cycle directly after FrameOut is a legal back-to-back frame: no error.
- LineErr and FrameErr may assert in the same cycle; FrameErr takes precedence for the position update.
- Outputs with DataValid=0 hold their last values; only DataValid, FrameOut, LineErr and FrameErr return to 0.

Optional Feature:
RASTER_EDGE_COUNT_EN.
- Defined:
  - An internal counter increments for every accepted pixel with PixelIn != 0.
  - It is cleared on frame start, including a FrameErr restart.
  - On FrameOut, EdgeCount takes the final count, including the last pixel, and holds it until the next FrameOut or Reset.
- Undefined: EdgeCount is tied to 0 and no counter logic is generated.

Test Plan:
All scenarios use IMG_W=4 and IMG_H=3.
- Reset then clean frame of pixels 1..12 with correct FrameIn/LineIn -> DataValid for 12 cycles, coordinates (0,0)..(3,2), data 1..12, FrameOut high with data=12 at (3,2), FrameCount=1, no errors.
- Two back-to-back clean frames, ValidIn toggling 1/0 -> gaps carry DataValid=0 with outputs held; FrameCount=2; second frame starts at (0,0).
- LineIn after 2 pixels of row 0 -> LineErr pulse; that pixel appears at (0,1). Then a 5th pixel in a row without LineIn -> LineErr pulse, pixel dropped, i stays 3.
- FrameIn at (2,1) -> FrameErr pulse, that pixel at (0,0), FrameCount unchanged, completes normally afterwards.
- Reset asserted at (1,1) mid-frame -> next cycle all outputs 0; pixels without FrameIn ignored; a later FrameIn restarts at (0,0).
- With RASTER_EDGE_COUNT_EN: frame with 5 non-zero pixels out of 12 -> EdgeCount=5 at FrameOut, held through the next frame until its FrameOut.

Source files
------------

// File: rtl/raster_out_handle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : raster_out_handle                                          |
// | Description : Converts the Pixel/Frame/Line stream into raster           |
// |               coordinates (i, j) and pixel data. Counts completed frames |
// |               and flags malformed lines/frames, resynchronising after    |
// |               them.                                                      |
// |               Optional: define RASTER_EDGE_COUNT_EN to report the number |
// |               of non-zero pixels in the last completed frame on          |
// |               EdgeCount. Otherwise EdgeCount is tied to 0.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module raster_out_handle #(
   parameter int PIX_W   = 8,
   parameter int COORD_W = 8,
   parameter int IMG_W   = 128,
   parameter int IMG_H   = 128,
   parameter int FCNT_W  = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [PIX_W-1:0]     PixelIn,
   input  logic                 ValidIn,
   input  logic                 FrameIn,
   input  logic                 LineIn,
   output logic [PIX_W-1:0]     data,
   output logic [COORD_W-1:0]   i,
   output logic [COORD_W-1:0]   j,
   output logic                 DataValid,
   output logic                 FrameOut,
   output logic [FCNT_W-1:0]    FrameCount,
   output logic                 LineErr,
   output logic                 FrameErr,
   output logic [2*COORD_W:0]   EdgeCount
);

   localparam logic [COORD_W-1:0] C_LAST_COL = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] C_LAST_ROW = COORD_W'(IMG_H - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [PIX_W-1:0]     data_q, data_d;
   logic [COORD_W-1:0]   i_q, i_d;
   logic [COORD_W-1:0]   j_q, j_d;
   logic                 dv_q, dv_d;
   logic                 fo_q, fo_d;
   logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
   logic                 lerr_q, lerr_d;
   logic                 ferr_q, ferr_d;

   // Pixel is accepted and placed at (w_col, w_row) this cycle
   logic                 w_emit;
   logic [COORD_W-1:0]   w_col;
   logic [COORD_W-1:0]   w_row;

   // Next-position, error and frame-completion decode; i_q/j_q double as the current position
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      i_d     = i_q;
      j_d     = j_q;
      dv_d    = 1'b0;
      fo_d    = 1'b0;
      fcnt_d  = fcnt_q;
      lerr_d  = 1'b0;
      ferr_d  = 1'b0;
      w_emit  = 1'b0;
      w_col   = i_q;
      w_row   = j_q;

      if (ValidIn) begin
         if (state_q == S_IDLE) begin
            // Stray pixels are dropped silently until a frame starts
            if (FrameIn) begin
               w_emit  = 1'b1;
               w_col   = '0;
               w_row   = '0;
               state_d = S_ACTIVE;
            end
         end else begin
            // Long line (end of row, no LineIn) or short line (LineIn mid-row)
            if ((i_q == C_LAST_COL) && !LineIn)
               lerr_d = 1'b1;
            if ((i_q != C_LAST_COL) && LineIn)
               lerr_d = 1'b1;

            if (FrameIn) begin
               // Premature frame start: restart the raster, stay active
               ferr_d = 1'b1;
               w_emit = 1'b1;
               w_col  = '0;
               w_row  = '0;
            end else if (LineIn) begin
               if (j_q == C_LAST_ROW) begin
                  // A further line would leave the frame: drop and resync
                  ferr_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  w_emit = 1'b1;
                  w_col  = '0;
                  w_row  = j_q + COORD_W'(1);
               end
            end else if (i_q != C_LAST_COL) begin
               w_emit = 1'b1;
               w_col  = i_q + COORD_W'(1);
            end
            // Otherwise a long-line pixel: dropped, position holds
         end
      end

      if (w_emit) begin
         data_d = PixelIn;
         i_d    = w_col;
         j_d    = w_row;
         dv_d   = 1'b1;
         if ((w_col == C_LAST_COL) && (w_row == C_LAST_ROW)) begin
            fo_d    = 1'b1;
            fcnt_d  = fcnt_q + FCNT_W'(1);
            state_d = S_IDLE;
         end
      end
   end

   // State and output registers; reset overrides any input activity
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         dv_q    <= 1'b0;
         fo_q    <= 1'b0;
         fcnt_q  <= '0;
         lerr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         i_q     <= i_d;
         j_q     <= j_d;
         dv_q    <= dv_d;
         fo_q    <= fo_d;
         fcnt_q  <= fcnt_d;
         lerr_q  <= lerr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data       = data_q;
   assign i          = i_q;
   assign j          = j_q;
   assign DataValid  = dv_q;
   assign FrameOut   = fo_q;
   assign FrameCount = fcnt_q;
   assign LineErr    = lerr_q;
   assign FrameErr   = ferr_q;

`ifdef RASTER_EDGE_COUNT_EN
   localparam int C_EC_W = 2*COORD_W + 1;

   logic [C_EC_W-1:0] ecnt_q, ecnt_d;
   logic [C_EC_W-1:0] edge_q, edge_d;

   // Running non-zero count; an emit at (0,0) is always a frame (re)start
   always_comb begin
      ecnt_d = ecnt_q;
      edge_d = edge_q;
      if (w_emit) begin
         ecnt_d = (((i_d == '0) && (j_d == '0)) ? '0 : ecnt_q)
                  + C_EC_W'(PixelIn != '0);
         if (fo_d)
            edge_d = ecnt_d;
      end
   end

   // Edge counter registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ecnt_q <= '0;
         edge_q <= '0;
      end else begin
         ecnt_q <= ecnt_d;
         edge_q <= edge_d;
      end
   end

   assign EdgeCount = edge_q;
`else
   assign EdgeCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_raster_out_handle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_raster_out_handle                                       |
// | Description : Directed self-checking bench for raster_out_handle with a  |
// |               4x3 image. Expected outputs are queued as each pixel is    |
// |               driven and compared one cycle later.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_raster_out_handle;

   logic        Clk     = 1'b0;
   logic        Reset   = 1'b1;
   logic [7:0]  PixelIn = '0;
   logic        ValidIn = 1'b0;
   logic        FrameIn = 1'b0;
   logic        LineIn  = 1'b0;
   logic [7:0]  data;
   logic [7:0]  i;
   logic [7:0]  j;
   logic        DataValid;
   logic        FrameOut;
   logic [15:0] FrameCount;
   logic        LineErr;
   logic        FrameErr;
   logic [16:0] EdgeCount;

   raster_out_handle #(
      .PIX_W   (8),
      .COORD_W (8),
      .IMG_W   (4),
      .IMG_H   (3),
      .FCNT_W  (16)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .PixelIn    (PixelIn),
      .ValidIn    (ValidIn),
      .FrameIn    (FrameIn),
      .LineIn     (LineIn),
      .data       (data),
      .i          (i),
      .j          (j),
      .DataValid  (DataValid),
      .FrameOut   (FrameOut),
      .FrameCount (FrameCount),
      .LineErr    (LineErr),
      .FrameErr   (FrameErr),
      .EdgeCount  (EdgeCount)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic        dv;
      logic [7:0]  data;
      logic [7:0]  i;
      logic [7:0]  j;
      logic        fo;
      logic [15:0] fcnt;
      logic        le;
      logic        fe;
      logic [16:0] ec;
   } exp_t;

   exp_t        sb[$];
   exp_t        held     = '0;
   int          run_cnt  = 0;
   int          checks   = 0;
   int          failures = 0;
   logic [11:0] mask     = 12'b1000_1010_0101;  // five non-zero pixels

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_out();
      exp_t e;
      e = sb.pop_front();
      chk("DataValid",  32'(DataValid),  32'(e.dv));
      chk("data",       32'(data),       32'(e.data));
      chk("i",          32'(i),          32'(e.i));
      chk("j",          32'(j),          32'(e.j));
      chk("FrameOut",   32'(FrameOut),   32'(e.fo));
      chk("FrameCount", 32'(FrameCount), 32'(e.fcnt));
      chk("LineErr",    32'(LineErr),    32'(e.le));
      chk("FrameErr",   32'(FrameErr),   32'(e.fe));
      chk("EdgeCount",  32'(EdgeCount),  32'(e.ec));
   endtask

   // Drive one input cycle, queue what must appear next cycle, then check it
   task automatic px(input logic v, input logic f, input logic l, input logic [7:0] p,
                     input logic edv, input int ei, input int ej,
                     input logic efo, input logic ele, input logic efe);
      exp_t e;
      ValidIn = v;
      FrameIn = f;
      LineIn  = l;
      PixelIn = p;
      if (edv) begin
         held.data = p;
         held.i    = 8'(ei);
         held.j    = 8'(ej);
         run_cnt   = (f ? 0 : run_cnt) + ((p != 8'd0) ? 1 : 0);
      end
      if (efo) begin
         held.fcnt = held.fcnt + 16'd1;
`ifdef RASTER_EDGE_COUNT_EN
         held.ec = 17'(run_cnt);
`endif
      end
      e    = held;
      e.dv = edv;
      e.fo = efo;
      e.le = ele;
      e.fe = efe;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      compare_out();
   endtask

   // Reset asserted alongside a valid frame-start pixel: reset must win
   task automatic do_reset();
      Reset   = 1'b1;
      ValidIn = 1'b1;
      FrameIn = 1'b1;
      LineIn  = 1'b1;
      PixelIn = 8'h55;
      held    = '0;
      run_cnt = 0;
      sb.push_back('0);
      @(posedge Clk);
      #1;
      Reset   = 1'b0;
      ValidIn = 1'b0;
      compare_out();
   endtask

   // Clean 4x3 frame; mode selects the pixel pattern, gaps inserts idle cycles
   task automatic frame(input int mode, input bit gaps);
      logic [7:0] p;
      for (int k = 0; k < 12; k++) begin
         if (mode == 0)      p = 8'(k + 1);
         else if (mode == 1) p = 8'(k + 32);
         else                p = mask[k] ? 8'(k + 1) : 8'd0;
         px(1, k == 0, (k % 4) == 0, p, 1, k % 4, k / 4, k == 11, 0, 0);
         if (gaps)
            px(0, 1, 1, 8'hEE, 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      do_reset();

      // Clean frame, then back-to-back frames with toggling ValidIn
      frame(0, 0);
      frame(1, 1);
      frame(0, 1);

      // Short line after two pixels, then a long line
      px(1, 1, 1, 8'h31, 1, 0, 0, 0, 0, 0);
      px(1, 0, 0, 8'h32, 1, 1, 0, 0, 0, 0);
      px(1, 0, 1, 8'h33, 1, 0, 1, 0, 1, 0);
      px(1, 0, 0, 8'h34, 1, 1, 1, 0, 0, 0);
      px(1, 0, 0, 8'h35, 1, 2, 1, 0, 0, 0);
      px(1, 0, 0, 8'h36, 1, 3, 1, 0, 0, 0);
      px(1, 0, 0, 8'h37, 0, 0, 0, 0, 1, 0);
      px(1, 0, 0, 8'h38, 0, 0, 0, 0, 1, 0);
      px(1, 0, 1, 8'h39, 1, 0, 2, 0, 0, 0);
      px(1, 0, 0, 8'h3A, 1, 1, 2, 0, 0, 0);
      px(1, 0, 0, 8'h3B, 1, 2, 2, 0, 0, 0);
      px(1, 0, 0, 8'h3C, 1, 3, 2, 1, 0, 0);

      // Premature FrameIn (with LineIn, so also a short line) at (2,1)
      for (int k = 0; k < 6; k++)
         px(1, k == 0, (k % 4) == 0, 8'(8'h40 + k), 1, k % 4, k / 4, 0, 0, 0);
      px(1, 1, 1, 8'h50, 1, 0, 0, 0, 1, 1);
      for (int k = 1; k < 12; k++)
         px(1, 0, (k % 4) == 0, 8'(8'h50 + k), 1, k % 4, k / 4, k == 11, 0, 0);

      // Short line on the last row would pass the frame end
      for (int k = 0; k < 10; k++)
         px(1, k == 0, (k % 4) == 0, 8'(8'h60 + k), 1, k % 4, k / 4, 0, 0, 0);
      px(1, 0, 1, 8'h6A, 0, 0, 0, 0, 1, 1);
      px(1, 0, 0, 8'h6B, 0, 0, 0, 0, 0, 0);
      px(1, 0, 1, 8'h6C, 0, 0, 0, 0, 0, 0);
      frame(0, 0);

      // Reset mid-frame at (1,1), stray pixels ignored, then a fresh frame
      for (int k = 0; k < 6; k++)
         px(1, k == 0, (k % 4) == 0, 8'(8'h70 + k), 1, k % 4, k / 4, 0, 0, 0);
      do_reset();
      px(1, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0);
      px(1, 0, 0, 8'h78, 0, 0, 0, 0, 0, 0);
      frame(0, 0);

      // Sparse frame (five non-zero pixels) then a full frame with gaps
      frame(2, 0);
      frame(0, 1);

      ValidIn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
